// File: rtl/load_data_align_pkg.sv
// Shared sizing defaults, FSM encoding and load-size saturation for load_data_align.
package load_data_align_pkg;

  localparam int LDA_NUM_BYTES = 16;
  localparam int LDA_AMT_W     = $clog2(LDA_NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    OUT     = 2'd2
  } state_t;

  // A zero or oversized request means a full line.
  function automatic int unsigned sat_size(input int unsigned size, input int unsigned num_bytes);
    if (size == 0 || size > num_bytes) return num_bytes;
    return size;
  endfunction

endpackage

// File: rtl/load_data_align_byte_rotate_right.sv
// Byte-granular right rotator built from mux2_8$ cells, one level per offset bit;
// mirror image of the left rotator used on the store path.
module mux2_8$ (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       s0,
  output logic [7:0] y
);
  assign y = s0 ? in1 : in0;
endmodule

module byte_rotate_right
  import load_data_align_pkg::*;
#(
  parameter int NUM_BYTES = LDA_NUM_BYTES,
  parameter int AMT_W     = $clog2(NUM_BYTES)
) (
  input  logic [AMT_W-1:0]       amt,
  input  logic [NUM_BYTES*8-1:0] in,
  output logic [NUM_BYTES*8-1:0] out
);

  localparam int W = NUM_BYTES * 8;

  // Level i moves byte (k + 2^i) down to byte k when amt[i] is set.
  for (genvar i = 0; i < AMT_W; i++) begin : g_lvl
    logic [W-1:0] lvl_in;
    logic [W-1:0] lvl_out;

    if (i == 0) begin : g_first
      assign lvl_in = in;
    end else begin : g_next
      assign lvl_in = g_lvl[i-1].lvl_out;
    end

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
      mux2_8$ u_mux (
        .in0 (lvl_in[k*8 +: 8]),
        .in1 (lvl_in[((k + (1 << i)) % NUM_BYTES)*8 +: 8]),
        .s0  (amt[i]),
        .y   (lvl_out[k*8 +: 8])
      );
    end
  end

  assign out = g_lvl[AMT_W-1].lvl_out;

endmodule

// File: rtl/load_data_align.sv
// Aligns a (possibly line-crossing) load out of one or two cache-line beats.
// Define LOAD_DATA_ALIGN_SEXT_EN to enable sign extension of short loads.
module load_data_align
  import load_data_align_pkg::*;
#(
  parameter int NUM_BYTES = LDA_NUM_BYTES,
  parameter int AMT_W     = $clog2(NUM_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_BYTES*8-1:0] in_data,
  input  logic [AMT_W-1:0]       in_offset,
  input  logic [AMT_W:0]         in_size,
  input  logic                   in_sext,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_BYTES*8-1:0] out_data
);

  localparam int W = NUM_BYTES * 8;

  state_t state, state_nxt;

  logic             accept;
  logic             first_beat;
  logic             final_beat;
  logic             split;
  logic [AMT_W:0]   in_size_sat;
  logic [AMT_W+1:0] end_byte;

  logic [W-1:0]     low_q;
  logic [AMT_W-1:0] off_q;
  logic [AMT_W:0]   size_q;

  logic [AMT_W-1:0] cur_off;
  logic [AMT_W:0]   cur_size;
  logic [W-1:0]     rot_lo_in;
  logic [W-1:0]     rot_hi_in;
  logic [W-1:0]     rot_lo;
  logic [W-1:0]     rot_hi;
  logic [W-1:0]     merged;
  logic [W-1:0]     result;
  logic [7:0]       fill;

`ifdef LOAD_DATA_ALIGN_SEXT_EN
  logic             sext_q;
  logic             cur_sext;
  logic [AMT_W-1:0] sign_idx;
  logic             sign;
`else
  logic             sext_unused;
  assign sext_unused = in_sext;
`endif

  assign in_ready    = (state == IDLE || state == WAIT_HI) && !rst;
  assign accept      = in_valid && in_ready;
  assign in_size_sat = (AMT_W+1)'(sat_size(32'(in_size), NUM_BYTES));
  assign end_byte    = (AMT_W+2)'(in_offset) + (AMT_W+2)'(in_size_sat);
  assign split       = end_byte > (AMT_W+2)'(NUM_BYTES);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    first_beat = 1'b0;
    final_beat = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          first_beat = 1'b1;
          if (split) begin
            state_nxt = WAIT_HI;
          end else begin
            final_beat = 1'b1;
            state_nxt  = OUT;
          end
        end
      end
      WAIT_HI: begin
        if (accept) begin
          final_beat = 1'b1;
          state_nxt  = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the live beat is the low line; in WAIT_HI the live beat is the high line.
  assign rot_lo_in = (state == IDLE)    ? in_data   : low_q;
  assign rot_hi_in = (state == WAIT_HI) ? in_data   : '0;
  assign cur_off   = (state == IDLE)    ? in_offset : off_q;
  assign cur_size  = (state == IDLE)    ? in_size_sat : size_q;
`ifdef LOAD_DATA_ALIGN_SEXT_EN
  assign cur_sext  = (state == IDLE)    ? in_sext   : sext_q;
  assign sign_idx  = AMT_W'(cur_size - 1'b1);
`endif

  byte_rotate_right #(.NUM_BYTES(NUM_BYTES), .AMT_W(AMT_W)) u_rot_lo (
    .amt (cur_off),
    .in  (rot_lo_in),
    .out (rot_lo)
  );

  byte_rotate_right #(.NUM_BYTES(NUM_BYTES), .AMT_W(AMT_W)) u_rot_hi (
    .amt (cur_off),
    .in  (rot_hi_in),
    .out (rot_hi)
  );

  // Bytes that ran off the end of the low line come from the high line.
  always_comb begin
    merged = '0;
    result = '0;
    fill   = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k < NUM_BYTES - int'(cur_off)) merged[k*8 +: 8] = rot_lo[k*8 +: 8];
      else                               merged[k*8 +: 8] = rot_hi[k*8 +: 8];
    end
`ifdef LOAD_DATA_ALIGN_SEXT_EN
    sign = merged[{sign_idx, 3'b111}];
    if (cur_sext && sign) fill = 8'hFF;
`endif
    result = merged;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k >= int'(cur_size)) result[k*8 +: 8] = fill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
`ifdef LOAD_DATA_ALIGN_SEXT_EN
      sext_q    <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (first_beat) begin
        low_q  <= in_data;
        off_q  <= in_offset;
        size_q <= in_size_sat;
`ifdef LOAD_DATA_ALIGN_SEXT_EN
        sext_q <= in_sext;
`endif
      end
      if (final_beat) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_data_align.sv
// Randomized bench for load_data_align against a byte-stream model of the load.
// Honours LOAD_DATA_ALIGN_SEXT_EN the same way as the design.
module tb_load_data_align;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_offset;
  logic [4:0]   in_size;
  logic         in_sext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int           checks;
  int           failures;
  logic [127:0] lastData;

  load_data_align #(.NUM_BYTES(16), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_offset (in_offset),
    .in_size   (in_size),
    .in_sext   (in_sext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // The load is the byte stream low||high starting at offset, cut to size, then filled.
  function automatic logic [127:0] modelLoad(input logic [127:0] lo, input logic [127:0] hi,
                                             input int off, input int sz, input bit sx);
    logic [7:0]   cat [32];
    logic [7:0]   fill;
    logic [127:0] res;
    int           n;
    n = (sz == 0 || sz > 16) ? 16 : sz;
    for (int i = 0; i < 16; i++) begin
      cat[i]      = lo[i*8 +: 8];
      cat[i + 16] = hi[i*8 +: 8];
    end
    fill = 8'h00;
`ifdef LOAD_DATA_ALIGN_SEXT_EN
    if (sx && cat[off + n - 1][7]) fill = 8'hFF;
`else
    if (sx) fill = 8'h00;
`endif
    res = '0;
    for (int k = 0; k < 16; k++) res[k*8 +: 8] = (k < n) ? cat[off + k] : fill;
    return res;
  endfunction

  function automatic logic [127:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one complete load from IDLE, holds the result for 'hold' cycles, then drains it.
  task automatic applyStimulus(input logic [127:0] lo, input logic [127:0] hi, input int off,
                               input int sz, input bit sx, input int hold);
    logic [127:0] expData;
    int           n;
    bit           split;
    n       = (sz == 0 || sz > 16) ? 16 : sz;
    split   = (off + n) > 16;
    expData = modelLoad(lo, hi, off, sz, sx);
    checkOutput("ready_idle", 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    in_data   = lo;
    in_offset = 4'(off);
    in_size   = 5'(sz);
    in_sext   = sx;
    @(posedge clk); #1;
    if (split) begin
      checkOutput("no_valid_wait_hi", 128'(out_valid), 128'(0));
      checkOutput("ready_wait_hi", 128'(in_ready), 128'(1));
      in_data   = hi;
      in_offset = 4'($urandom);
      in_size   = 5'($urandom);
      in_sext   = 1'($urandom);
      @(posedge clk); #1;
    end
    in_data = randLine();
    lastData = out_data;
    checkOutput("valid", 128'(out_valid), 128'(1));
    checkOutput("data", out_data, expData);
    checkOutput("ready_out", 128'(in_ready), 128'(0));
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput("valid_hold", 128'(out_valid), 128'(1));
      checkOutput("data_hold", out_data, expData);
      checkOutput("ready_hold", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("valid_drop", 128'(out_valid), 128'(0));
    checkOutput("ready_after", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] seqLine;
    logic [127:0] hiLine;
    logic [127:0] rl;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_offset = '0;
    in_size   = '0;
    in_sext   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seqLine[i*8 +: 8] = 8'(i);
      hiLine[i*8 +: 8]  = 8'(i + 16);
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_data", out_data, 128'(0));
    checkOutput("rst_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    checkOutput("ready_post_rst", 128'(in_ready), 128'(1));

    applyStimulus(seqLine, '0, 4, 4, 1'b0, 0);
    checkOutput("offset4_size4", lastData, 128'h07060504);

    applyStimulus(seqLine, hiLine, 14, 4, 1'b0, 1);
    checkOutput("split_14_4", lastData, 128'h11100F0E);

    rl = seqLine;
    rl[7*8 +: 8] = 8'h80;
    applyStimulus(rl, '0, 4, 4, 1'b1, 0);
`ifdef LOAD_DATA_ALIGN_SEXT_EN
    checkOutput("sext_neg", lastData, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_8006_0504);
`else
    checkOutput("sext_off", lastData, 128'h8006_0504);
`endif

    applyStimulus(seqLine, '0, 4, 4, 1'b0, 5);

    rl = randLine();
    applyStimulus(rl, '0, 0, 0, 1'b0, 0);
    checkOutput("size0_passthru", lastData, rl);
    rl = randLine();
    applyStimulus(rl, '0, 0, 16, 1'b1, 0);
    checkOutput("size16_passthru", lastData, rl);

    applyStimulus(seqLine, hiLine, 15, 2, 1'b0, 0);
    checkOutput("split_15_2", lastData, 128'h100F);

    // Reset while waiting for the high line must drop the load silently.
    in_valid  = 1'b1;
    in_data   = seqLine;
    in_offset = 4'd14;
    in_size   = 5'd4;
    in_sext   = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_wait_hi", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("abort_ready_rst", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_valid", 128'(out_valid), 128'(0));
    end
    applyStimulus(hiLine, '0, 2, 3, 1'b0, 0);
    checkOutput("abort_recover", lastData, 128'h141312);

    for (int it = 0; it < 40; it++) begin
      applyStimulus(randLine(), randLine(), int'($urandom_range(15, 0)),
                    int'($urandom_range(31, 0)), 1'($urandom), int'($urandom_range(2, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
